hiscore_port_arb: RTL
=====================

HISCORE_PORT_ARB -- requirements
Module: hiscore_port_arb

Interface
REQ-001 Parameter ADDR_W, default 6: hiscore RAM address width.
REQ-002 Parameter FIFO_DEPTH, default 4: download write buffer depth (power of two).
REQ-003 Parameter PAD, default 2: cycles pause_req is held after the last access.
REQ-004 Parameter TMO, default 65535: maximum cycles to wait for cpu_paused.
REQ-005 Port clk_sys, input, 1: sole clock.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port dl_active, input, 1: HPS nvram download in progress.
REQ-008 Port dl_wr / dl_addr / dl_data, input, 1/ADDR_W/8: HPS download write strobe, address and data.
REQ-009 Port nv_req / nv_we / nv_addr / nv_wdata, input, 1/1/ADDR_W/8: nvram-dump requester access.
REQ-010 Port nv_gnt, output, 1: nvram requester access accepted this cycle.
REQ-011 Port nv_rvalid / nv_rdata, output, 1/8: read return.
REQ-012 Port cpu_paused, input, 1: game CPU halted.
REQ-013 Port pause_req, output, 1: request CPU halt.
REQ-014 Port ram_addr / ram_wdata / ram_we, output, ADDR_W/8/1: game hiscore RAM port.
REQ-015 Port ram_rdata, input, 8: RAM read data, valid 1 cycle after the address is presented.
REQ-016 Port err_o, output, 1: sticky error flag (FIFO overflow or pause timeout).

Function
REQ-017 FSM states: IDLE, WAITP, DL, NV, PADH.
REQ-018 IDLE: dl_active -> WAITP (owner=DL); else nv_req -> WAITP (owner=NV); download has priority when both are present in the same cycle.
REQ-019 pause_req = 1 in WAITP, DL, NV and PADH; 0 in IDLE.
REQ-020 WAITP: cpu_paused -> owner state; the timeout counter increments each cycle; reaching TMO -> set err_o, flush the FIFO, go to IDLE.
REQ-021 Every dl_wr pushes {dl_addr, dl_data} into the FIFO in any state; a push while the FIFO is full drops the entry and sets err_o.
REQ-022 DL: pop one FIFO entry per cycle onto the RAM port with ram_we=1; exit to PADH when dl_active=0 and the FIFO is empty.
REQ-023 NV: nv_gnt = nv_req combinationally; a granted access drives the RAM port the same cycle; a granted read gives nv_rvalid=1 with nv_rdata=ram_rdata exactly 1 cycle later.
REQ-024 NV: nv_req=0 -> PADH; if dl_active rises, finish the current access, then go to DL without dropping pause_req.
REQ-025 PADH: count PAD cycles, then go to IDLE; a new request during PADH goes straight to the owner state (pause already held, CPU still paused).
REQ-026 cpu_paused falling while in DL or NV: stall RAM accesses (ram_we=0, nv_gnt=0) and return to WAITP, keeping the owner.
REQ-027 ram_we=0 and nv_gnt=0 outside DL/NV; ram_addr and ram_wdata hold their last values.
REQ-028 The FIFO uses wrap-around pointers with an extra MSB; a simultaneous push and pop when full succeeds with no overflow.
REQ-029 err_o clears only on reset.

Reset
REQ-030 Reset: state=IDLE, FIFO empty, counters=0, and pause_req, nv_gnt, nv_rvalid, ram_we, err_o = 0; ram_addr=0; ram_wdata=0.
REQ-031 Reset mid-operation abandons the access immediately; no RAM write occurs in the reset cycle.

Structure
REQ-032 The state enum and default parameter constants live in the shared package hiscore_pkg.
REQ-033 The FIFO is one sub-module, hs_wr_fifo.

Verification
REQ-034 dl_active with 3 writes (addr 0..2, data AA/BB/CC), cpu_paused 5 cycles later -> RAM writes in 3 consecutive cycles after WAITP exit; pause_req drops PAD+1 cycles after the last write.
REQ-035 5 dl_wr pulses before cpu_paused with FIFO_DEPTH=4 -> err_o=1; only the first 4 entries are written.
REQ-036 nv_req read at addr 0x10 (ram holds 0x5A) -> nv_gnt same cycle; nv_rvalid=1 with nv_rdata=0x5A next cycle.
REQ-037 nv_req and dl_active asserted the same cycle from IDLE -> DL served first, then NV; pause_req stays 1 throughout.
REQ-038 cpu_paused never asserts with TMO=16 -> err_o=1 at cycle 16; state returns to IDLE; pause_req=0.
REQ-039 reset pulse during DL -> all outputs are at their reset values in the same cycle; no further ram_we.

Source files
------------

// File: rtl/hiscore_pkg.sv
// Shared types and default constants for the hiscore RAM port arbiter.
package hiscore_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAITP,
      DL,
      NV,
      PADH
   } state_t;

   typedef enum logic {
      OWN_DL,
      OWN_NV
   } owner_t;

   localparam int unsigned ADDR_W_DEF     = 6;
   localparam int unsigned FIFO_DEPTH_DEF = 4;
   localparam int unsigned PAD_DEF        = 2;
   localparam int unsigned TMO_DEF        = 65535;

   // Bits needed to hold a count of 0..n.
   function automatic int unsigned cnt_w(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/hs_wr_fifo.sv
// Download write buffer: wrap-around pointers with an extra MSB to tell full from empty.
module hs_wr_fifo #(
   parameter int unsigned WIDTH = 14,
   parameter int unsigned DEPTH = 4
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             empty,
   output logic             full,
   output logic             last,
   output logic             overflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign count    = wr_ptr - rd_ptr;
   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign last     = (count == (AW+1)'(1));
   assign do_pop   = pop && !empty;
   // A pop in the same cycle frees the slot, so a push while full still lands.
   assign do_push  = push && (!full || do_pop);
   assign overflow = push && full && !do_pop;
   assign rdata    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/hiscore_port_arb.sv
// Arbitrates the game hiscore RAM between HPS nvram download and the nvram-dump
// requester, halting the game CPU around every access burst.
module hiscore_port_arb
   import hiscore_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int unsigned PAD        = PAD_DEF,
   parameter int unsigned TMO        = TMO_DEF
) (
   input  logic              clk_sys,
   input  logic              reset,
   input  logic              dl_active,
   input  logic              dl_wr,
   input  logic [ADDR_W-1:0] dl_addr,
   input  logic [7:0]        dl_data,
   input  logic              nv_req,
   input  logic              nv_we,
   input  logic [ADDR_W-1:0] nv_addr,
   input  logic [7:0]        nv_wdata,
   output logic              nv_gnt,
   output logic              nv_rvalid,
   output logic [7:0]        nv_rdata,
   input  logic              cpu_paused,
   output logic              pause_req,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [7:0]        ram_wdata,
   output logic              ram_we,
   input  logic [7:0]        ram_rdata,
   output logic              err_o
);

   localparam int unsigned EW = ADDR_W + 8;
   localparam int unsigned TW = cnt_w(TMO);
   localparam int unsigned PW = cnt_w(PAD);

   state_t            state, state_n;
   owner_t            owner, owner_n;
   logic [TW-1:0]     tcnt, tcnt_n;
   logic [PW-1:0]     pcnt, pcnt_n;
   logic [ADDR_W-1:0] addr_q;
   logic [7:0]        wdata_q;

   logic              fifo_pop;
   logic              fifo_flush;
   logic              fifo_empty;
   logic              fifo_full;
   logic              fifo_last;
   logic              fifo_ovf;
   logic [EW-1:0]     fifo_head;
   logic [ADDR_W-1:0] head_addr;
   logic [7:0]        head_data;
   logic              tmo_hit;

   hs_wr_fifo #(
      .WIDTH (EW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .push     (dl_wr),
      .pop      (fifo_pop),
      .flush    (fifo_flush),
      .wdata    ({dl_addr, dl_data}),
      .rdata    (fifo_head),
      .empty    (fifo_empty),
      .full     (fifo_full),
      .last     (fifo_last),
      .overflow (fifo_ovf)
   );

   assign {head_addr, head_data} = fifo_head;
   assign pause_req = (state != IDLE);
   assign nv_rdata  = nv_rvalid ? ram_rdata : 8'h00;

   // Next state and RAM port steering; the port falls back to the held address/data.
   always_comb begin
      state_n    = state;
      owner_n    = owner;
      tcnt_n     = tcnt;
      pcnt_n     = pcnt;
      fifo_pop   = 1'b0;
      fifo_flush = 1'b0;
      tmo_hit    = 1'b0;
      nv_gnt     = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = addr_q;
      ram_wdata  = wdata_q;
      case (state)
         IDLE: begin
            tcnt_n = '0;
            pcnt_n = '0;
            if (dl_active) begin
               state_n = WAITP;
               owner_n = OWN_DL;
            end else if (nv_req) begin
               state_n = WAITP;
               owner_n = OWN_NV;
            end
         end
         WAITP: begin
            pcnt_n = '0;
            if (cpu_paused) begin
               state_n = (owner == OWN_DL) ? DL : NV;
               tcnt_n  = '0;
            end else if (tcnt == TW'(TMO - 1)) begin
               state_n    = IDLE;
               tmo_hit    = 1'b1;
               fifo_flush = 1'b1;
               tcnt_n     = '0;
            end else begin
               tcnt_n = tcnt + TW'(1);
            end
         end
         DL: begin
            if (!cpu_paused) begin
               state_n = WAITP;
               tcnt_n  = '0;
            end else begin
               if (!fifo_empty) begin
                  fifo_pop  = 1'b1;
                  ram_we    = 1'b1;
                  ram_addr  = head_addr;
                  ram_wdata = head_data;
               end
               // Leave on the cycle the final entry goes out, not one later.
               if (!dl_active && !dl_wr && (fifo_empty || fifo_last)) begin
                  state_n = PADH;
                  pcnt_n  = '0;
               end
            end
         end
         NV: begin
            if (!cpu_paused) begin
               state_n = WAITP;
               tcnt_n  = '0;
            end else begin
               nv_gnt = nv_req;
               if (nv_req) begin
                  ram_we    = nv_we;
                  ram_addr  = nv_addr;
                  ram_wdata = nv_wdata;
               end
               if (dl_active) begin
                  state_n = DL;
                  owner_n = OWN_DL;
               end else if (!nv_req) begin
                  state_n = PADH;
                  pcnt_n  = '0;
               end
            end
         end
         PADH: begin
            if (dl_active || nv_req) begin
               owner_n = dl_active ? OWN_DL : OWN_NV;
               tcnt_n  = '0;
               if (!cpu_paused)    state_n = WAITP;
               else if (dl_active) state_n = DL;
               else                state_n = NV;
            end else if (pcnt == PW'(PAD - 1)) begin
               state_n = IDLE;
               pcnt_n  = '0;
            end else begin
               pcnt_n = pcnt + PW'(1);
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= OWN_DL;
         tcnt      <= '0;
         pcnt      <= '0;
         err_o     <= 1'b0;
         nv_rvalid <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
      end else begin
         state     <= state_n;
         owner     <= owner_n;
         tcnt      <= tcnt_n;
         pcnt      <= pcnt_n;
         err_o     <= err_o | fifo_ovf | tmo_hit;
         nv_rvalid <= nv_gnt & ~nv_we;
         addr_q    <= ram_addr;
         wdata_q   <= ram_wdata;
      end
   end

endmodule
